// File: rtl/top_with_mod.sv
// rtl/top_with_mod.sv - BPSK transmitter: serialises a captured word MSB-first onto a 16-sample sine carrier
module top_with_mod #(
  parameter int SAMPLES_PER_BIT = 32,
  parameter int DATA_W          = 64,
  parameter int AMP             = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_carrier,
  input  logic                start,
  input  logic [DATA_W-1:0]   data_in,
  output logic                done,
  output logic signed [8:0]   mod_out,
  output logic                in_data
);

  localparam int SW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, TX, DONE} state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
  logic [3:0]             phase_q, phase_d;
  logic                   done_q, done_d;
  logic signed [8:0]      mod_q, mod_d;
  logic signed [8:0]      carrier;

  // The carrier is derived from clk; the legacy carrier pin is deliberately left unconnected.
  logic unused_clk_carrier;
  assign unused_clk_carrier = clk_carrier;

  // Sine magnitudes held as 16-bit fractions so the table rescales with AMP.
  function automatic logic signed [8:0] sine_lut(input logic [3:0] ph);
    int frac;
    int mag;
    case (ph[2:0])
      3'd1, 3'd7: frac = 25080;
      3'd2, 3'd6: frac = 46341;
      3'd3, 3'd5: frac = 60547;
      3'd4:       frac = 65536;
      default:    frac = 0;
    endcase
    mag = (AMP * frac + 32768) >>> 16;
    sine_lut = ph[3] ? -9'(mag) : 9'(mag);
  endfunction

  assign carrier = sine_lut(phase_q);

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    sample_cnt_d = sample_cnt_q;
    phase_d      = phase_q;
    done_d       = done_q;
    mod_d        = 9'sd0;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          shreg_d      = data_in;
          bit_cnt_d    = '0;
          sample_cnt_d = '0;
          phase_d      = 4'd0;
          state_d      = TX;
        end
      end
      TX: begin
        mod_d        = shreg_q[DATA_W-1] ? carrier : -carrier;
        phase_d      = phase_q + 4'd1;
        sample_cnt_d = sample_cnt_q + SW'(1);
        if (sample_cnt_q == LAST_SAMPLE) begin
          sample_cnt_d = '0;
          shreg_d      = shreg_q << 1;
          bit_cnt_d    = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        // Level-sensitive start: only a release re-arms the transmitter.
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      sample_cnt_q <= '0;
      phase_q      <= 4'd0;
      done_q       <= 1'b0;
      mod_q        <= 9'sd0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      phase_q      <= phase_d;
      done_q       <= done_d;
      mod_q        <= mod_d;
    end
  end

  assign done    = done_q;
  assign mod_out = mod_q;
  assign in_data = shreg_q[DATA_W-1];

endmodule

// File: tb/tb_top_with_mod.sv
// tb/tb_top_with_mod.sv - directed-vector bench for the BPSK transmitter
module tb_top_with_mod;

  logic               clk;
  logic               reset;
  logic               clk_carrier;
  logic               start;
  logic [63:0]        data_in;
  logic               done;
  logic signed [8:0]  mod_out;
  logic               in_data;

  int errors = 0;
  int checks = 0;
  int lutv [16] = '{0, 98, 180, 236, 255, 236, 180, 98,
                    0, -98, -180, -236, -255, -236, -180, -98};
  longint samp [2048];

  top_with_mod dut (
    .clk         (clk),
    .reset       (reset),
    .clk_carrier (clk_carrier),
    .start       (start),
    .data_in     (data_in),
    .done        (done),
    .mod_out     (mod_out),
    .in_data     (in_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial clk_carrier = 1'b0;
  always #3 clk_carrier = ~clk_carrier;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_sample(input logic [63:0] d, input int k);
    logic b;
    b = d[63 - k / 32];
    return b ? longint'(lutv[k % 16]) : -longint'(lutv[k % 16]);
  endfunction

  // Called at a negedge; start is held high through TX and DONE, then released.
  task automatic send(input logic [63:0] d, input bit flip);
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      if (flip && k == 100) data_in = ~d;
      chk("in_data", longint'(in_data), longint'(d[63 - k / 32]));
      if (k == 0) chk("mod_first", longint'(mod_out), 0);
      else begin
        samp[k-1] = longint'(mod_out);
        chk("mod", longint'(mod_out), exp_sample(d, k - 1));
      end
      chk("done_tx", longint'(done), 0);
    end
    @(negedge clk);
    samp[2047] = longint'(mod_out);
    chk("mod_last", longint'(mod_out), exp_sample(d, 2047));
    chk("done_rise", longint'(done), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("done_hold", longint'(done), 1);
      chk("mod_hold", longint'(mod_out), 0);
      chk("in_hold", longint'(in_data), 0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_clr", longint'(done), 0);
    chk("mod_idle", longint'(mod_out), 0);
    @(negedge clk);
    chk("done_idle", longint'(done), 0);
    chk("mod_idle2", longint'(mod_out), 0);
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b1;
    data_in = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_done", longint'(done), 0);
      chk("rst_mod", longint'(mod_out), 0);
      chk("rst_in", longint'(in_data), 0);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_mod", longint'(mod_out), 0);
    chk("idle_done", longint'(done), 0);

    send(64'hABCD123789E3F456, 1'b0);
    chk("s4_pos", samp[4], 255);
    chk("s36_neg", samp[36], -255);
    chk("s0", samp[0], 0);
    chk("s66", samp[66], 180);

    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("ones_s12", samp[12], -255);
    chk("ones_s2047", samp[2047], -98);

    send(64'h0, 1'b0);
    chk("zero_s4", samp[4], -255);
    chk("zero_s1", samp[1], -98);

    send(64'h5A5A_0F0F_C3C3_9696, 1'b1);

    data_in = 64'h8000_0000_0000_0001;
    start   = 1'b1;
    @(posedge clk);
    repeat (10 * 32 + 5) @(negedge clk);
    chk("pre_rst_in", longint'(in_data), 0);
    reset = 1'b0;
    #1;
    chk("abort_mod", longint'(mod_out), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_in", longint'(in_data), 0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_mod", longint'(mod_out), 0);
    send(64'h8000_0000_0000_0001, 1'b0);
    chk("rst_s4", samp[4], 255);
    chk("rst_s36", samp[36], -255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
